multicycle_memory: RTL and testbench

MULTICYCLE_MEMORY -- requirements
Module: multicycle_memory

---
 rtl/mem_pkg.sv | 6 +
 rtl/multicycle_memory_if.sv | 12 +
 rtl/mem_delay_pipe.sv | 32 +++
 rtl/multicycle_memory.sv | 33 +++
 tb/tb_multicycle_memory.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared word width and default read latency for the multicycle memory
package mem_pkg;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEF_LATENCY = 4;
endpackage

// File: rtl/multicycle_memory_if.sv
// multicycle_memory_if: request/response bus between a requester and the memory
interface multicycle_memory_if;
  import mem_pkg::*;
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  modport master(output enable, wr, addr, data_in, input data_out, data_valid);
  modport slave(input enable, wr, addr, data_in, output data_out, data_valid);
endinterface

// File: rtl/mem_delay_pipe.sv
// mem_delay_pipe: LATENCY-stage shift register carrying {valid, data} of captured reads
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o
);
  logic [LATENCY-1:0] valid_q;
  logic [WORD_W-1:0]  data_q [LATENCY];
  // shift captured reads one stage per cycle; reset drops everything in flight at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end
  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
endmodule

// File: rtl/multicycle_memory.sv
// multicycle_memory: always-ready word memory with a fixed, fully pipelined read latency
module multicycle_memory
  import mem_pkg::*;
#(
  parameter int LATENCY        = DEF_LATENCY,
  parameter int WORD_ADDR_BITS = 15
) (
  input logic                clk,
  input logic                rst,
  multicycle_memory_if.slave bus
);
  logic [WORD_W-1:0]         mem_q [2**WORD_ADDR_BITS];
  logic [WORD_ADDR_BITS-1:0] idx;
  logic                      rd_d;
  logic [WORD_W-1:0]         rd_data_d;
  logic                      unused_addr;
  assign idx         = bus.addr[WORD_ADDR_BITS:1];
  assign rd_d        = bus.enable & ~bus.wr;
  assign rd_data_d   = mem_q[idx];
  assign unused_addr = ^bus.addr;
  // commit writes at the accepting edge; contents survive reset, but no request is taken while rst is high
  always_ff @(posedge clk) begin
    if (!rst && bus.enable && bus.wr) mem_q[idx] <= bus.data_in;
  end
  mem_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_d),
    .data_i  (rd_data_d),
    .valid_o (bus.data_valid),
    .data_o  (bus.data_out)
  );
endmodule

// File: tb/tb_multicycle_memory.sv
// tb_multicycle_memory: directed checks of latency, ordering, reset and address folding
module tb_multicycle_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  int          total = 0;
  int          bad = 0;
  int          lat [4] = '{1, 4, 8, 4};
  logic        v [4];
  logic [15:0] q [4];

  always #5 clk = ~clk;

  multicycle_memory_if b1 ();
  multicycle_memory_if b4 ();
  multicycle_memory_if b8 ();
  multicycle_memory_if bw ();

  assign b1.enable = en; assign b1.wr = wr; assign b1.addr = addr; assign b1.data_in = din;
  assign b4.enable = en; assign b4.wr = wr; assign b4.addr = addr; assign b4.data_in = din;
  assign b8.enable = en; assign b8.wr = wr; assign b8.addr = addr; assign b8.data_in = din;
  assign bw.enable = en; assign bw.wr = wr; assign bw.addr = addr; assign bw.data_in = din;

  assign v[0] = b1.data_valid; assign q[0] = b1.data_out;
  assign v[1] = b4.data_valid; assign q[1] = b4.data_out;
  assign v[2] = b8.data_valid; assign q[2] = b8.data_out;
  assign v[3] = bw.data_valid; assign q[3] = bw.data_out;

  multicycle_memory #(.LATENCY(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  multicycle_memory #(.LATENCY(4)) d4 (.clk(clk), .rst(rst), .bus(b4));
  multicycle_memory #(.LATENCY(8)) d8 (.clk(clk), .rst(rst), .bus(b8));
  multicycle_memory #(.LATENCY(4), .WORD_ADDR_BITS(4)) dw (.clk(clk), .rst(rst), .bus(bw));

  task automatic cyc(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    en = e; wr = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  // idle drives junk write fields that must be ignored while enable is low
  task automatic idle();
    cyc(1'b0, 1'b1, 16'h0010, 16'hFFFF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (v[k] !== 1'b0 || q[k] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_state dut%0d: valid=%b data=%h, need valid=0 data=0000", k, v[k], q[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic        ev;
    logic [15:0] eq;
    cyc(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) idle();
      for (int k = 0; k < 4; k++) begin
        ev = (s == lat[k] - 1);
        eq = ev ? 16'hBEEF : 16'h0000;
        total++;
        if (v[k] !== ev || q[k] !== eq) begin
          bad++;
          $display("FAIL single_read dut%0d step%0d: valid=%b data=%h, need valid=%b data=%h", k, s, v[k], q[k], ev, eq);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ev;
    logic [15:0] eq;
    cyc(1'b1, 1'b1, 16'h0000, 16'h1111);
    cyc(1'b1, 1'b1, 16'h0002, 16'h2222);
    cyc(1'b1, 1'b1, 16'h0004, 16'h3333);
    for (int s = 0; s < 9; s++) begin
      if (s < 3) cyc(1'b1, 1'b0, 16'(2 * s), 16'h0000);
      else idle();
      ev = (s >= 3 && s <= 5);
      eq = s == 3 ? 16'h1111 : s == 4 ? 16'h2222 : s == 5 ? 16'h3333 : 16'h0000;
      for (int k = 1; k < 4; k += 2) begin
        total++;
        if (v[k] !== ev || q[k] !== eq) begin
          bad++;
          $display("FAIL back_to_back dut%0d step%0d: valid=%b data=%h, need valid=%b data=%h", k, s, v[k], q[k], ev, eq);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic        ev;
    logic [15:0] eq;
    cyc(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    cyc(1'b1, 1'b1, 16'h0022, 16'h5555);
    for (int s = 0; s < 8; s++) begin
      if (s == 0) cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
      else if (s == 2) cyc(1'b1, 1'b0, 16'h0022, 16'h0000);
      else idle();
      ev = (s == 3 || s == 5);
      eq = s == 3 ? 16'hAAAA : s == 5 ? 16'h5555 : 16'h0000;
      for (int k = 1; k < 4; k += 2) begin
        total++;
        if (v[k] !== ev || q[k] !== eq) begin
          bad++;
          $display("FAIL gap_reads dut%0d step%0d: valid=%b data=%h, need valid=%b data=%h", k, s, v[k], q[k], ev, eq);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic        ev;
    logic [15:0] eq;
    cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0022, 16'h0000);
    idle();
    idle();
    total++;
    if (v[1] !== 1'b1 || q[1] !== 16'hAAAA) begin
      bad++;
      $display("FAIL pre_reset_pulse: valid=%b data=%h, need valid=1 data=aaaa", v[1], q[1]);
    end
    rst = 1'b1;
    en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'hDEAD;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (v[k] !== 1'b0 || q[k] !== 16'h0000) begin
        bad++;
        $display("FAIL async_clear dut%0d: valid=%b data=%h, need valid=0 data=0000", k, v[k], q[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      idle();
      for (int k = 0; k < 4; k++) begin
        total++;
        if (v[k] !== 1'b0) begin
          bad++;
          $display("FAIL stale_pulse dut%0d step%0d: valid=%b, need valid=0", k, s, v[k]);
        end
      end
    end
    for (int s = 0; s < 6; s++) begin
      if (s == 0) cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
      else if (s == 1) cyc(1'b1, 1'b0, 16'h0022, 16'h0000);
      else idle();
      ev = (s == 3 || s == 4);
      eq = s == 3 ? 16'hAAAA : s == 4 ? 16'h5555 : 16'h0000;
      total++;
      if (v[1] !== ev || q[1] !== eq) begin
        bad++;
        $display("FAIL post_reset_contents step%0d: valid=%b data=%h, need valid=%b data=%h", s, v[1], q[1], ev, eq);
      end
    end
  endtask

  task automatic test_wrap();
    logic        ev;
    logic [15:0] eq;
    logic [15:0] a;
    cyc(1'b1, 1'b1, 16'h0007, 16'h1234);
    cyc(1'b1, 1'b1, 16'h0002, 16'hCAFE);
    for (int s = 0; s < 10; s++) begin
      a = s == 0 ? 16'h0006 : s == 1 ? 16'h0022 : s == 2 ? 16'h0010 : 16'h0002;
      if (s < 4) cyc(1'b1, 1'b0, a, 16'h0000);
      else idle();
      ev = (s >= 3 && s <= 6);
      eq = s == 3 ? 16'h1234 : s == 4 ? 16'h5555 : s == 5 ? 16'hBEEF : s == 6 ? 16'hCAFE : 16'h0000;
      total++;
      if (v[1] !== ev || q[1] !== eq) begin
        bad++;
        $display("FAIL addr_fold_wide step%0d: valid=%b data=%h, need valid=%b data=%h", s, v[1], q[1], ev, eq);
      end
      eq = s == 4 ? 16'hCAFE : eq;
      total++;
      if (v[3] !== ev || q[3] !== eq) begin
        bad++;
        $display("FAIL addr_wrap_narrow step%0d: valid=%b data=%h, need valid=%b data=%h", s, v[3], q[3], ev, eq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
